// File: rtl/store_sequencer.sv
// store_sequencer: writes BYTES bytes of a selected source register to
// consecutive memory addresses starting at nn, little-endian, using a
// three-phase (W0/W1/W2) write cycle per byte, then pulses done.
// Optional feature: define STORE_SEQUENCER_WAIT_EN to let WAIT stretch W1;
// when undefined WAIT is ignored and W1 always lasts one cycle.
module store_sequencer #(
  parameter int unsigned BYTES  = 2,
  parameter int unsigned REGS   = 4,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    start,
  input  logic [2:0]              reg_sel,
  input  logic [ADDR_W-1:0]       nn,
  input  logic [REGS*BYTES*8-1:0] reg_data,
  input  logic                    WAIT,
  output logic                    busy,
  output logic [ADDR_W-1:0]       addr,
  output logic [7:0]              dout,
  output logic                    w0,
  output logic                    w1,
  output logic                    w2,
  output logic                    wr,
  output logic                    done
);

  typedef enum logic [2:0] {IDLE, W0, W1, W2, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [ADDR_W-1:0]     nn_q, nn_d;
  logic [BYTES*8-1:0]    data_q, data_d;
  logic [BYTES*8-1:0]    sel_data;
  logic [31:0]           data_pad;
  logic                  wait_hold;

`ifdef STORE_SEQUENCER_WAIT_EN
  assign wait_hold = WAIT;
`else
  logic unused_wait;
  assign unused_wait = WAIT;
  assign wait_hold   = 1'b0;
`endif

  // Source register mux; out-of-range selects read as zero.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < REGS; k++) begin
      if (32'(reg_sel) == k) sel_data = reg_data[k*BYTES*8 +: BYTES*8];
    end
  end

  // Byte lanes padded to 32 bits so the idx-based byte select is always in range.
  assign data_pad = 32'(data_q);

  // State and captured operands, asynchronously cleared.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      nn_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nn_q    <= nn_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nn_d    = nn_q;
    data_d  = data_q;
    busy    = 1'b0;
    w0      = 1'b0;
    w1      = 1'b0;
    w2      = 1'b0;
    wr      = 1'b0;
    done    = 1'b0;
    addr    = '0;
    dout    = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          nn_d    = nn;
          data_d  = sel_data;
          idx_d   = '0;
          state_d = W0;
        end
      end
      W0: begin
        busy    = 1'b1;
        w0      = 1'b1;
        addr    = nn_q + ADDR_W'(idx_q);
        dout    = data_pad[{idx_q, 3'b000} +: 8];
        state_d = W1;
      end
      W1: begin
        busy    = 1'b1;
        w1      = 1'b1;
        wr      = 1'b1;
        addr    = nn_q + ADDR_W'(idx_q);
        dout    = data_pad[{idx_q, 3'b000} +: 8];
        state_d = wait_hold ? W1 : W2;
      end
      W2: begin
        busy = 1'b1;
        w2   = 1'b1;
        wr   = 1'b1;
        addr = nn_q + ADDR_W'(idx_q);
        dout = data_pad[{idx_q, 3'b000} +: 8];
        if (32'(idx_q) + 32'd1 < BYTES) begin
          idx_d   = idx_q + 2'd1;
          state_d = W0;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: default instance (BYTES=2, REGS=4)
// plus a BYTES=4, REGS=3 instance for the out-of-range register select.
module tb_store_sequencer;

  logic        CLK, RESET, WAIT;
  logic        start, start2;
  logic [2:0]  reg_sel, reg_sel2;
  logic [15:0] nn, nn2;
  logic [63:0] reg_data;
  logic [95:0] reg_data2;

  logic        busy, w0, w1, w2, wr, done;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        busy2, w02, w12, w22, wr2, done2;
  logic [15:0] addr2;
  logic [7:0]  dout2;

  logic [29:0] obs1, obs2;
  assign obs1 = {busy, w0, w1, w2, wr, done, addr, dout};
  assign obs2 = {busy2, w02, w12, w22, wr2, done2, addr2, dout2};

  int tests = 0;
  int fails = 0;
  int cnt;

  store_sequencer #(.BYTES(2), .REGS(4), .ADDR_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .reg_sel(reg_sel), .nn(nn),
    .reg_data(reg_data), .WAIT(WAIT), .busy(busy), .addr(addr), .dout(dout),
    .w0(w0), .w1(w1), .w2(w2), .wr(wr), .done(done)
  );

  store_sequencer #(.BYTES(4), .REGS(3), .ADDR_W(16)) dut4 (
    .CLK(CLK), .RESET(RESET), .start(start2), .reg_sel(reg_sel2), .nn(nn2),
    .reg_data(reg_data2), .WAIT(WAIT), .busy(busy2), .addr(addr2), .dout(dout2),
    .w0(w02), .w1(w12), .w2(w22), .wr(wr2), .done(done2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Expected {busy,w0,w1,w2,wr,done,addr,dout} at cycle c of an n-byte
  // operation (cycle 1 = first W0, cycle 3n+1 = DONE, anything else idle).
  function automatic logic [29:0] model(input int c, input int n,
                                        input logic [15:0] base,
                                        input logic [31:0] data);
    logic [31:0] sh;
    int ph, b;
    model = '0;
    if (c >= 1 && c <= 3*n) begin
      ph = (c - 1) % 3;
      b  = (c - 1) / 3;
      sh = data >> (8*b);
      case (ph)
        0:       model[29:24] = 6'b110000;
        1:       model[29:24] = 6'b101010;
        default: model[29:24] = 6'b100110;
      endcase
      model[23:8] = base + 16'(b);
      model[7:0]  = sh[7:0];
    end else if (c == 3*n + 1) begin
      model[29:24] = 6'b100001;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; WAIT = 1'b0;
    start = 1'b0; reg_sel = '0; nn = '0; reg_data = '0;
    start2 = 1'b0; reg_sel2 = '0; nn2 = '0; reg_data2 = '0;

    // Reset state, before any clock edge.
    #2;
    chk("reset_dut", 32'(obs1), 32'd0);
    chk("reset_dut4", 32'(obs2), 32'd0);
    #10;

    // Basic 2-byte store; start taken on the first edge after release.
    RESET = 1'b0;
    reg_data = {16'hCAFE, 16'hBEEF, 16'h7E81, 16'h5AA5};
    reg_sel = 3'd2; nn = 16'h1234; start = 1'b1;
    tick();
    start = 1'b0; nn = 16'h9999; reg_sel = 3'd1; reg_data = ~reg_data;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("basic_c%0d", c), 32'(obs1), 32'(model(c, 2, 16'h1234, 32'hBEEF)));
      tick();
    end
    chk("basic_idle", 32'(obs1), 32'd0);

    // Address wrap from 0xFFFF to 0x0000.
    reg_data = {16'hCAFE, 16'hBEEF, 16'h7E81, 16'h5AA5};
    reg_sel = 3'd0; nn = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("wrap_c%0d", c), 32'(obs1), 32'(model(c, 2, 16'hFFFF, 32'h5AA5)));
      tick();
    end

    // BYTES=4, REGS=3, reg_sel=5 selects nothing: four zero bytes.
    reg_data2 = 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC;
    reg_sel2 = 3'd5; nn2 = 16'h00FE; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      chk($sformatf("oor4_c%0d", c), 32'(obs2), 32'(model(c, 4, 16'h00FE, 32'h0)));
      tick();
    end
    chk("oor4_idle", 32'(obs2), 32'd0);

    // start re-pulsed during W2 and during DONE is ignored.
    reg_sel = 3'd1; nn = 16'h4000; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("repulse_c%0d", c), 32'(obs1), 32'(model(c, 2, 16'h4000, 32'h7E81)));
      if (done) cnt++;
      start = (c == 3 || c == 7);
      tick();
    end
    start = 1'b0;
    if (done) cnt++;
    chk("repulse_idle1", 32'(obs1), 32'd0);
    tick();
    if (done) cnt++;
    chk("repulse_idle2", 32'(obs1), 32'd0);
    chk("repulse_done_count", 32'(cnt), 32'd1);

    // WAIT held for two edges in the first W1.
    reg_sel = 3'd3; nn = 16'h2000; start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) cnt++;
      if (i == 1) WAIT = 1'b1;
      if (i == 2) begin
`ifdef STORE_SEQUENCER_WAIT_EN
        chk("wait_w1_held", {30'd0, w1, wr}, 32'd3);
`else
        chk("wait_ignored_w2", {30'd0, w1, wr}, 32'd1);
`endif
      end
      if (i == 3) WAIT = 1'b0;
      tick();
    end
`ifdef STORE_SEQUENCER_WAIT_EN
    chk("wait_busy_cycles", 32'(cnt), 32'd9);
`else
    chk("wait_busy_cycles", 32'(cnt), 32'd7);
`endif

    // Reset asserted mid-W1 of byte 1 abandons the operation.
    reg_sel = 3'd2; nn = 16'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    chk("rst_pre_w1", 32'(obs1), 32'(model(5, 2, 16'h1234, 32'hBEEF)));
    #2 RESET = 1'b1;
    #1 chk("rst_async_zero", 32'(obs1), 32'd0);
    cnt = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (done || wr) cnt++;
    end
    chk("rst_no_done_wr", 32'(cnt), 32'd0);
    RESET = 1'b0; start = 1'b1; reg_sel = 3'd2; nn = 16'h0100;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("post_rst_c%0d", c), 32'(obs1), 32'(model(c, 2, 16'h0100, 32'hBEEF)));
      tick();
    end
    chk("post_rst_idle", 32'(obs1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_sequencer.md
STORE_SEQUENCER -- requirements
Module: store_sequencer

Interface
REQ-001 SHALL have parameter BYTES, default 2: bytes stored per operation, legal range 1..4.
REQ-002 SHALL have parameter REGS, default 4: number of source registers, legal range 1..8.
REQ-003 SHALL have parameter ADDR_W, default 16: address width, legal range 8..32.
REQ-004 SHALL have port CLK, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request a store; sampled only in IDLE.
REQ-007 SHALL have port reg_sel, input, 3 bits: source register index.
REQ-008 SHALL have port nn, input, ADDR_W bits: target base address.
REQ-009 SHALL have port reg_data, input, REGS*BYTES*8 bits: flattened register file, register k at bits [k*BYTES*8 +: BYTES*8].
REQ-010 SHALL have port WAIT, input, 1 bit: memory wait request, active-high.
REQ-011 SHALL have port busy, output, 1 bit: operation in progress.
REQ-012 SHALL have port addr, output, ADDR_W bits: write address.
REQ-013 SHALL have port dout, output, 8 bits: write data byte.
REQ-014 SHALL have ports w0, w1 and w2, each output, 1 bit: one-hot write-cycle phase strobes.
REQ-015 SHALL have port wr, output, 1 bit: memory write enable.
REQ-016 SHALL have port done, output, 1 bit: one-cycle completion pulse (next-opcode-fetch trigger).

Function
REQ-017 SHALL implement states IDLE, W0, W1, W2 and DONE, plus an internal byte counter idx of width 2.
REQ-018 SHALL, in IDLE with start=1, capture nn, the selected register's BYTES*8 bits, and idx=0, then go to W0 on the next edge.
REQ-019 SHALL capture data of all zeros when reg_sel >= REGS; the operation otherwise proceeds normally.
REQ-020 SHALL step W0 -> W1 -> W2 unconditionally, except as REQ-021 states.
REQ-021 SHALL stay in W1 while WAIT=1 at the edge; wr and w1 remain asserted throughout the wait.
REQ-022 SHALL, in W2, go to W0 with idx+1 if idx < BYTES-1, else go to DONE.
REQ-023 SHALL return DONE to IDLE after exactly one cycle.
REQ-024 SHALL assert w0, w1 and w2 only in their matching state, with at most one high at any time.
REQ-025 SHALL assert wr in W1 and W2 only.
REQ-026 SHALL assert busy in W0, W1, W2 and DONE.
REQ-027 SHALL assert done in DONE only.
REQ-028 SHALL drive addr = captured nn + idx, modulo 2^ADDR_W, in W0..W2, so that 0xFFFF+1 wraps to 0x0000.
REQ-029 SHALL drive addr = 0 outside W0..W2.
REQ-030 SHALL drive dout = byte idx of the captured data (little-endian, byte 0 = bits [7:0]) in W0..W2, and 0 otherwise.
REQ-031 SHALL ignore start while busy; no queuing.
REQ-032 SHALL ignore start asserted in DONE; a new operation is accepted from IDLE only.
REQ-033 SHALL ignore changes to nn, reg_sel and reg_data after capture.
REQ-034 SHALL take 3*BYTES+1 cycles from the first W0 to the end of DONE when no wait states occur.

Reset
REQ-035 SHALL, on RESET=1, immediately force state IDLE, idx=0, captured registers 0, and all outputs 0, independent of CLK.
REQ-036 SHALL, on reset mid-operation, abandon the operation with no done pulse and no further wr.
REQ-037 SHALL, after reset release, accept start on the first rising edge at which RESET=0.

Configuration
REQ-038 SHALL support the macro STORE_SEQUENCER_WAIT_EN.
REQ-039 SHALL, when STORE_SEQUENCER_WAIT_EN is defined, behave per REQ-021.
REQ-040 SHALL, when STORE_SEQUENCER_WAIT_EN is undefined, ignore WAIT (port retained, unused), so that W1 always lasts exactly one cycle.

Verification
REQ-041 SHALL cover: BYTES=2, reg_sel=2, reg2=0xBEEF, nn=0x1234, start pulse -> addr 0x1234/dout 0xEF for 3 cycles, then 0x1235/0xBE for 3 cycles, done on cycle 7, busy 7 cycles.
REQ-042 SHALL cover: nn=0xFFFF, BYTES=2 -> second byte written at addr 0x0000.
REQ-043 SHALL cover: WAIT_EN defined, WAIT=1 for 2 edges in the first W1 -> W1 lasts 3 cycles, total busy 9 cycles; with WAIT_EN undefined -> busy 7 cycles.
REQ-044 SHALL cover: start re-pulsed during W2 and during DONE -> ignored, single done pulse, IDLE afterwards.
REQ-045 SHALL cover: RESET asserted mid-W1 of byte 1 -> all outputs 0 immediately, no done; a new start after release runs a full 7-cycle operation.
REQ-046 SHALL cover: BYTES=4, REGS=3, reg_sel=5 -> four writes at nn..nn+3 with dout=0x00, then a done pulse.
